// File: rtl/freq_pkg.sv
// Shared constants and FSM encodings for the frequency/period meter and the
// divider logic that runs off the 50 MHz system clock.
package freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meas_state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Divider terminal counts: CLK_50M cycles per output period.
  localparam int unsigned CYC_500HZ = CLK_HZ / 500;
  localparam int unsigned CYC_50HZ  = CLK_HZ / 50;
  localparam int unsigned CYC_5HZ   = CLK_HZ / 5;
  localparam int unsigned CYC_05HZ  = CLK_HZ * 2;

  localparam int unsigned FREQ_CNT_W   = 28;
  localparam int unsigned FREQ_TIMEOUT = CYC_05HZ;

  function automatic int unsigned cycles_for_hz(input int unsigned hz);
    return CLK_HZ / hz;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector. The level output
// is taken from the same stage the pulses are derived from, so they line up.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level_o = sync_q[2];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/freq_meter.sv
// Period / high-time meter for slow asynchronous square waves, counted in
// CLK_50M cycles, with a valid/ready result register and overrun/no-signal flags.
module freq_meter
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W   = FREQ_CNT_W,
  parameter int unsigned TIMEOUT = FREQ_TIMEOUT
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             SIG_IN,
  input  logic             MEAS_EN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             PERIOD_VALID,
  input  logic             PERIOD_READY,
  output logic             OVERRUN,
  output logic             NO_SIGNAL
);

  localparam int unsigned      CMP_W   = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0] TO_LAST = CMP_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic sig_level;
  logic sig_rise;
  logic sig_fall;

  sync_edge u_sync (
    .clk_i  (CLK_50M),
    .rst_ni (RST_N),
    .sig_i  (SIG_IN),
    .level_o(sig_level),
    .rise_o (sig_rise),
    .fall_o (sig_fall)
  );

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             nosig_q, nosig_d;

  logic             timeout_hit;
  logic             start_meas;
  logic             publish;
  logic             to_fire;
  logic             accept;
  logic [CNT_W-1:0] pub_high;
  logic [CMP_W-1:0] cnt_wide;

  assign cnt_wide    = CMP_W'(cnt_q);
  assign timeout_hit = (cnt_wide == TO_LAST);
  assign accept      = valid_q & PERIOD_READY;
  // A period with no observed fall is reported as high for its whole length.
  assign pub_high    = fall_seen_q ? hi_cap_q : cnt_q;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (MEAS_EN) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!MEAS_EN)     state_d = ST_IDLE;
        else if (sig_rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!MEAS_EN)                      state_d = ST_IDLE;
        else if (!sig_rise && timeout_hit) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_meas = 1'b0;
    publish    = 1'b0;
    to_fire    = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (MEAS_EN) begin
          if (sig_rise)         start_meas = 1'b1;
          else if (timeout_hit) to_fire    = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (MEAS_EN) begin
          if (sig_rise)         publish = 1'b1;
          else if (timeout_hit) to_fire = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Cycle counter: restarts at 1 on every accepted rise, saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!MEAS_EN || state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (start_meas || publish) begin
      cnt_d = CNT_ONE;
    end else if (to_fire) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    hi_cap_d    = hi_cap_q;
    fall_seen_d = fall_seen_q;
    if (start_meas || publish) begin
      fall_seen_d = 1'b0;
    end else if (state_q == ST_MEASURE) begin
      if (sig_fall)   hi_cap_d    = cnt_q;
      if (!sig_level) fall_seen_d = 1'b1;
    end
  end

  always_comb begin
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q & ~accept;
    if (publish && valid_q && !PERIOD_READY) begin
      overrun_d = 1'b1;
    end else if (publish) begin
      period_d = cnt_q;
      high_d   = pub_high;
      valid_d  = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    nosig_d = nosig_q;
    if (to_fire)  nosig_d = 1'b1;
    if (sig_rise) nosig_d = 1'b0;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      fall_seen_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      nosig_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      fall_seen_q <= fall_seen_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      nosig_q     <= nosig_d;
    end
  end

  assign PERIOD       = period_q;
  assign HIGH_TIME    = high_q;
  assign PERIOD_VALID = valid_q;
  assign OVERRUN      = overrun_q;
  assign NO_SIGNAL    = nosig_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a timestamp-based reference model checked every
// cycle on two instances (28-bit and 8-bit counters), plus literal spot checks.
module tb_freq_meter;

  localparam int TO = 1000;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sig;
  logic [1:0]  en;
  logic [1:0]  rdy;
  logic [1:0]  val;
  logic [1:0]  ovr;
  logic [1:0]  nos;
  logic [27:0] per_a, hi_a;
  logic [7:0]  per_b, hi_b;

  freq_meter #(.CNT_W(28), .TIMEOUT(TO)) u_a (
    .CLK_50M(clk), .RST_N(rst_n), .SIG_IN(sig[0]), .MEAS_EN(en[0]),
    .PERIOD(per_a), .HIGH_TIME(hi_a), .PERIOD_VALID(val[0]),
    .PERIOD_READY(rdy[0]), .OVERRUN(ovr[0]), .NO_SIGNAL(nos[0])
  );

  freq_meter #(.CNT_W(8), .TIMEOUT(TO)) u_b (
    .CLK_50M(clk), .RST_N(rst_n), .SIG_IN(sig[1]), .MEAS_EN(en[1]),
    .PERIOD(per_b), .HIGH_TIME(hi_b), .PERIOD_VALID(val[1]),
    .PERIOD_READY(rdy[1]), .OVERRUN(ovr[1]), .NO_SIGNAL(nos[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin samples are delayed by the documented 3-clock detector latency; elapsed
  // time is kept as (edge index - base) and clipped to the counter's maximum.
  longint   cyc;
  int       mode [2];      // 0 off, 1 waiting for first rise, 2 running
  longint   base [2];
  longint   hi   [2];
  bit       fs   [2];
  longint   mp   [2];
  longint   mh   [2];
  bit       mv   [2];
  bit       mo   [2];
  bit       mn   [2];
  bit [3:0] hist [2];

  function automatic longint maxv(input int i);
    return (i == 0) ? 64'd268435455 : 64'd255;
  endfunction

  task automatic model_step(input int i);
    bit     r, f, pub, acc;
    longint e, c, pp, ph;
    r   = hist[i][2] & ~hist[i][3];
    f   = ~hist[i][2] & hist[i][3];
    e   = cyc - base[i];
    c   = (e > maxv(i)) ? maxv(i) : e;
    pub = 1'b0;
    pp  = 0;
    ph  = 0;
    if (r) mn[i] = 1'b0;
    if (!en[i]) begin
      mode[i] = 0;
    end else if (mode[i] == 0) begin
      mode[i] = 1;
      base[i] = cyc + 1;
    end else if (mode[i] == 1) begin
      if (r) begin
        mode[i] = 2; base[i] = cyc; fs[i] = 1'b0;
      end else if (c == TO - 1) begin
        mn[i] = 1'b1; base[i] = cyc + 1;
      end
    end else begin
      if (r) begin
        pub = 1'b1; pp = c; ph = fs[i] ? hi[i] : c;
        base[i] = cyc; fs[i] = 1'b0;
      end else if (c == TO - 1) begin
        mn[i] = 1'b1; mode[i] = 1; base[i] = cyc + 1;
      end else if (f) begin
        hi[i] = c; fs[i] = 1'b1;
      end
    end
    acc = mv[i] & rdy[i];
    if (pub) begin
      if (mv[i] && !rdy[i]) begin
        mo[i] = 1'b1;
      end else begin
        mp[i] = pp; mh[i] = ph; mv[i] = 1'b1; mo[i] = 1'b0;
      end
    end else if (acc) begin
      mv[i] = 1'b0; mo[i] = 1'b0;
    end
    hist[i] = {hist[i][2:0], sig[i]};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        mode[i] = 0; base[i] = 0; hi[i] = 0; fs[i] = 1'b0;
        mp[i] = 0; mh[i] = 0; mv[i] = 1'b0; mo[i] = 1'b0; mn[i] = 1'b0;
        hist[i] = 4'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- per-cycle compare ----------------
  function automatic longint dper(input int i);
    return (i == 0) ? longint'(per_a) : longint'(per_b);
  endfunction
  function automatic longint dhi(input int i);
    return (i == 0) ? longint'(hi_a) : longint'(hi_b);
  endfunction

  int     pubs [2];
  longint lp   [2];
  longint lh   [2];
  bit     pv   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pubs[i] = 0; lp[i] = 0; lh[i] = 0; pv[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.PERIOD", i),       dper(i),        mp[i]);
      chk($sformatf("u%0d.HIGH_TIME", i),    dhi(i),         mh[i]);
      chk($sformatf("u%0d.PERIOD_VALID", i), longint'(val[i]), longint'(mv[i]));
      chk($sformatf("u%0d.OVERRUN", i),      longint'(ovr[i]), longint'(mo[i]));
      chk($sformatf("u%0d.NO_SIGNAL", i),    longint'(nos[i]), longint'(mn[i]));
      if (val[i] && !pv[i]) begin
        pubs[i]++;
        lp[i] = dper(i);
        lh[i] = dhi(i);
      end
      pv[i] = val[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic square(input int i, input int per, input int high, input int count);
    for (int k = 0; k < count; k++) begin
      sig[i] = 1'b1;
      tick(high);
      sig[i] = 1'b0;
      tick(per - high);
    end
  endtask

  int p0;

  initial begin
    rst_n = 1'b0; sig = '0; en = '0; rdy = '0;
    tick(3);
    chk("reset_valid",  longint'(val[0]), 0);
    chk("reset_period", longint'(per_a), 0);
    chk("reset_nosig",  longint'(nos[0]), 0);
    chk("reset_ovr_b",  longint'(ovr[1]), 0);
    rst_n = 1'b1;
    tick(2);

    // period 20, high 10, consumer always ready
    en[0] = 1'b1; rdy[0] = 1'b1; p0 = pubs[0];
    square(0, 20, 10, 6);
    chk("t1_pub_count", pubs[0], p0 + 5);
    chk("t1_period",    lp[0], 20);
    chk("t1_high",      lh[0], 10);
    chk("t1_model_per", mp[0], 20);

    // period 37, high 5, consumer stalls -> first result held, overrun
    en[0] = 1'b0; tick(5); rdy[0] = 1'b0; en[0] = 1'b1;
    square(0, 37, 5, 4);
    chk("t2_valid",  longint'(val[0]), 1);
    chk("t2_period", longint'(per_a), 37);
    chk("t2_high",   longint'(hi_a), 5);
    chk("t2_ovr",    longint'(ovr[0]), 1);
    rdy[0] = 1'b1;
    tick(2);
    chk("t2_valid_drop", longint'(val[0]), 0);
    chk("t2_ovr_clear",  longint'(ovr[0]), 0);

    // input stuck low -> NO_SIGNAL around 1000 cycles, then recovery
    en[0] = 1'b0; tick(3); en[0] = 1'b1;
    tick(990);
    chk("t3_nosig_early", longint'(nos[0]), 0);
    tick(20);
    chk("t3_nosig_set",   longint'(nos[0]), 1);
    chk("t3_valid_low",   longint'(val[0]), 0);
    p0 = pubs[0];
    square(0, 20, 10, 1);
    chk("t3_nosig_clear", longint'(nos[0]), 0);
    square(0, 20, 10, 2);
    chk("t3_pub_count",   pubs[0], p0 + 2);
    chk("t3_period",      lp[0], 20);

    // reset in the middle of a period
    square(0, 20, 10, 2);
    sig[0] = 1'b1;
    tick(12);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_period", longint'(per_a), 0);
    chk("t4_rst_high",   longint'(hi_a), 0);
    chk("t4_rst_valid",  longint'(val[0]), 0);
    chk("t4_rst_ovr",    longint'(ovr[0]), 0);
    chk("t4_rst_nosig",  longint'(nos[0]), 0);
    sig[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    p0 = pubs[0];
    tick(10);
    square(0, 20, 10, 1);
    chk("t4_one_rise_nopub", pubs[0], p0);
    square(0, 20, 10, 1);
    chk("t4_two_rise_pub",   pubs[0], p0 + 1);
    chk("t4_period",         lp[0], 20);

    // enable dropped mid-period -> partial period discarded
    sig[0] = 1'b1;
    tick(7);
    en[0] = 1'b0; tick(3); en[0] = 1'b1;
    tick(3); sig[0] = 1'b0; tick(10);
    p0 = pubs[0];
    square(0, 20, 10, 3);
    chk("t5_pub_count", pubs[0], p0 + 2);
    chk("t5_period",    lp[0], 20);
    chk("t5_high",      lh[0], 10);

    // 8-bit counter, period 300 -> saturates at 255
    en[1] = 1'b1; rdy[1] = 1'b1;
    square(1, 300, 150, 3);
    chk("t6_pub_count", pubs[1], 2);
    chk("t6_period",    lp[1], 255);
    chk("t6_high",      lh[1], 150);
    chk("t6_model_per", mp[1], 255);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
